// File: rtl/cluster_vpf_injector_pkg.sv
// Shared constants and FSM encoding for the VPF injector, cluster counter and checker.
package cluster_vpf_injector_pkg;
    localparam int N_VPF       = 768;
    localparam int CNT_W       = 11;
    localparam int LATENCY     = 9;
    localparam int OVF_THRESH  = 8;
    localparam int OFFSET_STEP = 97;
    localparam int OFF_W       = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } inj_state_e;
endpackage

// File: rtl/cluster_vpf_injector_vpf_pattern_gen.sv
// Wrapped thermometer: n contiguous ones starting at bit off, wrapping past the top bit.
module vpf_pattern_gen
    import cluster_vpf_injector_pkg::*;
(
    input  logic [CNT_W-1:0] n_i,
    input  logic [OFF_W-1:0] off_i,
    output logic [N_VPF-1:0] vpfs_o
);
    logic [N_VPF-1:0] therm;
    logic [CNT_W-1:0] back_sh;

    always_comb begin
        therm   = ~({N_VPF{1'b1}} << n_i);
        // off = 0 gives a back shift of N_VPF, which clears the wrap term
        back_sh = CNT_W'(N_VPF) - CNT_W'(off_i);
        vpfs_o  = (therm << off_i) | (therm >> back_sh);
    end
endmodule

// File: rtl/cluster_vpf_injector.sv
// Test-pattern transmitter for the cluster-count path with a latency-matched expected-count stream.
module cluster_vpf_injector
    import cluster_vpf_injector_pkg::*;
(
    input  logic             clock4x,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] n_vpf_i,
    input  logic [7:0]       n_bx_i,
    input  logic [OFF_W-1:0] offset_i,
    output logic [N_VPF-1:0] vpfs_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             exp_valid_o,
    output logic [CNT_W-1:0] exp_cnt_o,
    output logic             exp_ovf_o
);
    inj_state_e       state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [OFF_W-1:0] off_q, off_d, off_step;
    logic [7:0]       bx_q, bx_d;
    logic [1:0]       phase_q, phase_d;
    logic [3:0]       drain_q, drain_d;
    logic [N_VPF-1:0] vpfs_q, vpfs_d, pat;
    logic             done_q, done_d;
    logic             tag_vld_q, tag_vld_d;
    logic [CNT_W-1:0] tag_cnt_q, tag_cnt_d;
    logic [LATENCY-1:0] vld_dl_q, vld_dl_d;
    logic [CNT_W-1:0] cnt_dl_q [LATENCY];
    logic [CNT_W-1:0] cnt_dl_d [LATENCY];
    logic             ovf_q, ovf_d;
    logic             go;

    assign go = (state_q == ST_IDLE) && start_i && !abort_i;

    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go) state_d = (n_bx_i != 8'd0) ? ST_RUN : ST_DRAIN;
            ST_RUN: begin
                if (abort_i) state_d = ST_IDLE;
                else if (phase_q == 2'd3 && bx_q == 8'd1) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort_i || drain_q == 4'(LATENCY)) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Pattern generator sees next-cycle n/off so vpfs_o updates on the start edge itself
    vpf_pattern_gen u_pat (
        .n_i    (n_d),
        .off_i  (off_d),
        .vpfs_o (pat)
    );

    always_comb begin
        n_d      = n_q;
        off_d    = off_q;
        bx_d     = bx_q;
        phase_d  = phase_q;
        drain_d  = '0;
        off_step = off_q + OFF_W'(OFFSET_STEP);
        if (go) begin
            n_d     = (n_vpf_i > CNT_W'(N_VPF)) ? CNT_W'(N_VPF) : n_vpf_i;
            off_d   = (offset_i >= OFF_W'(N_VPF)) ? offset_i - OFF_W'(N_VPF) : offset_i;
            bx_d    = n_bx_i;
            phase_d = 2'd0;
        end else if (state_q == ST_RUN) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
                off_d = (off_step >= OFF_W'(N_VPF)) ? off_step - OFF_W'(N_VPF) : off_step;
                bx_d  = bx_q - 8'd1;
            end
        end else if (state_q == ST_DRAIN) begin
            drain_d = drain_q + 4'd1;
        end

        vpfs_d    = (state_d == ST_RUN) ? pat : '0;
        tag_vld_d = (state_d == ST_RUN);
        tag_cnt_d = (state_d == ST_RUN) ? n_d : '0;
        done_d    = (state_q == ST_DRAIN) && (state_d == ST_IDLE) && !abort_i;

        vld_dl_d    = {vld_dl_q[LATENCY-2:0], tag_vld_q};
        cnt_dl_d[0] = tag_cnt_q;
        for (int i = 1; i < LATENCY; i++) cnt_dl_d[i] = cnt_dl_q[i-1];
        ovf_d = (cnt_dl_q[LATENCY-1] > CNT_W'(OVF_THRESH));
    end

    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) begin
            n_q       <= '0;
            off_q     <= '0;
            bx_q      <= '0;
            phase_q   <= '0;
            drain_q   <= '0;
            vpfs_q    <= '0;
            done_q    <= 1'b0;
            tag_vld_q <= 1'b0;
            tag_cnt_q <= '0;
            vld_dl_q  <= '0;
            for (int i = 0; i < LATENCY; i++) cnt_dl_q[i] <= '0;
            ovf_q     <= 1'b0;
        end else begin
            n_q       <= n_d;
            off_q     <= off_d;
            bx_q      <= bx_d;
            phase_q   <= phase_d;
            drain_q   <= drain_d;
            vpfs_q    <= vpfs_d;
            done_q    <= done_d;
            tag_vld_q <= tag_vld_d;
            tag_cnt_q <= tag_cnt_d;
            vld_dl_q  <= vld_dl_d;
            for (int i = 0; i < LATENCY; i++) cnt_dl_q[i] <= cnt_dl_d[i];
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        done_o      = done_q;
        vpfs_o      = vpfs_q;
        exp_valid_o = vld_dl_q[LATENCY-1];
        exp_cnt_o   = cnt_dl_q[LATENCY-1];
        exp_ovf_o   = ovf_q;
    end
endmodule
